// File: rtl/mem_pkg.sv
// Shared encodings and the load lane-select/extension helper for the MEM stage.
package mem_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_D  = 3'd5;
    localparam logic [2:0] LD_WU = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_READY   = 2'd2,
        ST_DISCARD = 2'd3
    } ms_state_e;

    // Works on a 64-bit view; a 32-bit datapath zero-pads rdata and addr_lo[2]
    // and keeps the low half, which yields correct 32-bit sign extension.
    function automatic logic [63:0] lane_extend(input logic [63:0] rdata,
                                                input logic [2:0]  addr_lo,
                                                input logic [2:0]  ld_op);
        logic [2:0]  lane;
        logic [63:0] sh;
        case (ld_op)
            LD_H, LD_HU: lane = {addr_lo[2:1], 1'b0};
            LD_W, LD_WU: lane = {addr_lo[2], 2'b00};
            LD_D:        lane = 3'd0;
            default:     lane = addr_lo;
        endcase
        sh = rdata >> {lane, 3'b000};
        case (ld_op)
            LD_B:    lane_extend = {{56{sh[7]}},  sh[7:0]};
            LD_BU:   lane_extend = {56'd0,        sh[7:0]};
            LD_H:    lane_extend = {{48{sh[15]}}, sh[15:0]};
            LD_HU:   lane_extend = {48'd0,        sh[15:0]};
            LD_W:    lane_extend = {{32{sh[31]}}, sh[31:0]};
            LD_WU:   lane_extend = {32'd0,        sh[31:0]};
            default: lane_extend = rdata;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of load data.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   rdata_i,
    input  logic [LANE_W-1:0] addr_lo_i,
    input  logic [2:0]        ld_op_i,
    output logic [XLEN-1:0]   data_o
);

    logic [63:0] rd64;
    logic [63:0] ext64;
    logic [2:0]  a3;

    assign rd64   = 64'(rdata_i);
    assign a3     = 3'(addr_lo_i);
    assign ext64  = lane_extend(rd64, a3, ld_op_i);
    assign data_o = ext64[XLEN-1:0];

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: split-transaction data SRAM, WB back-pressure, flush of
// outstanding loads, and load data extension.
module mem_stage_ws
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            es_to_ms_valid,
    output logic            ms_allowin,
    input  logic [PC_W-1:0] es_pc,
    input  logic            es_res_from_mem,
    input  logic            es_mem_req,
    input  logic            es_rf_we,
    input  logic [RA_W-1:0] es_rf_waddr,
    input  logic [XLEN-1:0] es_alu_result,
    input  logic [2:0]      es_ld_op,
    input  logic            data_sram_data_ok,
    input  logic [XLEN-1:0] data_sram_rdata,
    input  logic            ms_flush,
    input  logic            ws_allowin,
    output logic            ms_to_ws_valid,
    output logic [PC_W-1:0] ms_pc,
    output logic            ms_rf_we,
    output logic [RA_W-1:0] ms_rf_waddr,
    output logic [XLEN-1:0] ms_rf_wdata,
    output logic            ms_fwd_blocked
);

    localparam int LANE_W = $clog2(XLEN / 8);

    ms_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic            res_from_mem_q;
    logic            we_q;
    logic [RA_W-1:0] waddr_q;
    logic [XLEN-1:0] alu_q;
    logic [2:0]      ld_op_q;
    logic [XLEN-1:0] rdata_buf_q;
    logic [XLEN-1:0] ext_data;
    logic            accept;

    assign ms_allowin     = (state_q == ST_EMPTY) | ((state_q == ST_READY) & ws_allowin);
    assign accept         = es_to_ms_valid & ms_allowin & ~ms_flush;
    assign ms_to_ws_valid = (state_q == ST_READY);
    assign ms_fwd_blocked = (state_q == ST_WAIT);
    assign ms_pc          = pc_q;
    assign ms_rf_we       = we_q & ms_to_ws_valid;
    assign ms_rf_waddr    = waddr_q;
    assign ms_rf_wdata    = res_from_mem_q ? ext_data : alu_q;

    load_extend #(.XLEN(XLEN)) u_ext (
        .rdata_i   (rdata_buf_q),
        .addr_lo_i (alu_q[LANE_W-1:0]),
        .ld_op_i   (ld_op_q),
        .data_o    (ext_data)
    );

    // Next state: flush beats accept; stray responses outside WAIT/DISCARD are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = es_mem_req ? ST_WAIT : ST_READY;
            end
            ST_WAIT: begin
                if (ms_flush)               state_d = data_sram_data_ok ? ST_EMPTY : ST_DISCARD;
                else if (data_sram_data_ok) state_d = ST_READY;
            end
            ST_READY: begin
                if (ms_flush)        state_d = ST_EMPTY;
                else if (accept)     state_d = es_mem_req ? ST_WAIT : ST_READY;
                else if (ws_allowin) state_d = ST_EMPTY;
            end
            ST_DISCARD: begin
                if (data_sram_data_ok) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Latch the EX instruction fields on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q           <= '0;
            res_from_mem_q <= 1'b0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            alu_q          <= '0;
            ld_op_q        <= LD_W;
        end else if (accept) begin
            pc_q           <= es_pc;
            res_from_mem_q <= es_res_from_mem;
            we_q           <= es_rf_we;
            waddr_q        <= es_rf_waddr;
            alu_q          <= es_alu_result;
            ld_op_q        <= es_ld_op;
        end
    end

    // Capture the load response only when it will be consumed (WAIT, not flushed).
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                    rdata_buf_q <= '0;
        else if ((state_q == ST_WAIT) & data_sram_data_ok & ~ms_flush) rdata_buf_q <= data_sram_rdata;
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench for mem_stage_ws (XLEN=32 and XLEN=64) and load_extend.
module tb_mem_stage_ws;
    import mem_pkg::*;

    logic clk, reset;
    int   n_chk = 0, n_bad = 0;
    logic stray_ok = 1'b0;

    // XLEN=32 instance signals
    logic        v, req, rfm, we, dok, fl, wsa;
    logic [31:0] pc, alu, rd;
    logic [4:0]  wa;
    logic [2:0]  op;
    logic        allowin, mvalid, mwe, fwd;
    logic [31:0] mpc, wdata;
    logic [4:0]  mwa;

    // XLEN=64 instance signals
    logic        v6, dok6;
    logic [63:0] alu6, rd6;
    logic [2:0]  op6;
    logic        allowin6, mvalid6, mwe6, fwd6;
    logic [31:0] mpc6;
    logic [63:0] wdata6;
    logic [4:0]  mwa6;

    // standalone extender
    logic [31:0] x_rd, x_out;
    logic [1:0]  x_a;
    logic [2:0]  x_op;

    mem_stage_ws #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .es_to_ms_valid(v), .ms_allowin(allowin),
        .es_pc(pc), .es_res_from_mem(rfm), .es_mem_req(req), .es_rf_we(we),
        .es_rf_waddr(wa), .es_alu_result(alu), .es_ld_op(op),
        .data_sram_data_ok(dok), .data_sram_rdata(rd), .ms_flush(fl),
        .ws_allowin(wsa), .ms_to_ws_valid(mvalid), .ms_pc(mpc), .ms_rf_we(mwe),
        .ms_rf_waddr(mwa), .ms_rf_wdata(wdata), .ms_fwd_blocked(fwd));

    mem_stage_ws #(.XLEN(64)) u64 (
        .clk(clk), .reset(reset), .es_to_ms_valid(v6), .ms_allowin(allowin6),
        .es_pc(32'h900), .es_res_from_mem(1'b1), .es_mem_req(1'b1), .es_rf_we(1'b1),
        .es_rf_waddr(5'd3), .es_alu_result(alu6), .es_ld_op(op6),
        .data_sram_data_ok(dok6), .data_sram_rdata(rd6), .ms_flush(1'b0),
        .ws_allowin(1'b1), .ms_to_ws_valid(mvalid6), .ms_pc(mpc6), .ms_rf_we(mwe6),
        .ms_rf_waddr(mwa6), .ms_rf_wdata(wdata6), .ms_fwd_blocked(fwd6));

    load_extend #(.XLEN(32)) u_x (.rdata_i(x_rd), .addr_lo_i(x_a), .ld_op_i(x_op), .data_o(x_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [31:0] p, input logic r_fm, input logic r_q,
                         input logic w, input logic [4:0] a, input logic [31:0] res,
                         input logic [2:0] o);
        v = 1'b1; pc = p; rfm = r_fm; req = r_q; we = w; wa = a; alu = res; op = o;
    endtask

    task automatic idle();
        v = 1'b0; pc = '0; rfm = 1'b0; req = 1'b0; we = 1'b0; wa = '0; alu = '0; op = LD_W;
    endtask

    task automatic ld64(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp);
        v6 = 1'b1; op6 = o; alu6 = a;
        tick();
        v6 = 1'b0; dok6 = 1'b1; rd6 = d;
        tick();
        dok6 = 1'b0;
        #1 chk({tag, "_valid"}, 64'(mvalid6), 64'd1);
        chk(tag, wdata6, exp);
        tick();
    endtask

    // A response is only legal while a request is outstanding.
    always @(posedge clk) begin
        if (!reset && !stray_ok && dok && (u32.state_q == ST_EMPTY || u32.state_q == ST_READY)) begin
            n_bad++;
            $display("FAIL proto32 got=data_ok state=%0d exp=no data_ok", u32.state_q);
        end
        if (!reset && dok6 && (u64.state_q == ST_EMPTY || u64.state_q == ST_READY)) begin
            n_bad++;
            $display("FAIL proto64 got=data_ok state=%0d exp=no data_ok", u64.state_q);
        end
    end

    initial begin
        logic [31:0] vals [4];
        reset = 1'b1; idle(); dok = 1'b0; rd = '0; fl = 1'b0; wsa = 1'b1;
        v6 = 1'b0; dok6 = 1'b0; alu6 = '0; rd6 = '0; op6 = LD_W;
        x_rd = '0; x_a = '0; x_op = LD_W;
        #1;
        chk("rst_valid", 64'(mvalid), 64'd0);
        chk("rst_pc",    64'(mpc),    64'd0);
        chk("rst_we",    64'(mwe),    64'd0);
        chk("rst_wdata", 64'(wdata),  64'd0);
        tick(); tick();
        reset = 1'b0;

        // standalone extender vectors
        x_rd = 32'h80FF_0000; x_a = 2'd3; x_op = LD_B;  #1 chk("x_b3",  64'(x_out), 64'hFFFF_FF80);
        x_a = 2'd2; x_op = LD_BU;                       #1 chk("x_bu2", 64'(x_out), 64'h0000_00FF);
        x_rd = 32'hBEEF_1234; x_a = 2'd3; x_op = LD_H;  #1 chk("x_h3",  64'(x_out), 64'hFFFF_BEEF);
        x_a = 2'd0; x_op = LD_H;                        #1 chk("x_h0",  64'(x_out), 64'h0000_1234);
        x_op = LD_W;                                    #1 chk("x_w",   64'(x_out), 64'hBEEF_1234);

        // ld.b at 0x1003, response 3 cycles after accept
        issue(32'h100, 1, 1, 1, 5'd5, 32'h1003, LD_B);
        #1 chk("t1_allowin", 64'(allowin), 64'd1);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            #1 chk("t1_fwd", 64'(fwd), 64'd1);
            chk("t1_allowin_w", 64'(allowin), 64'd0);
            chk("t1_valid_w", 64'(mvalid), 64'd0);
            if (i == 2) begin dok = 1'b1; rd = 32'h80FF_0000; end
            tick();
        end
        dok = 1'b0; rd = '0;
        #1 chk("t1_fwd_off", 64'(fwd), 64'd0);
        chk("t1_valid", 64'(mvalid), 64'd1);
        chk("t1_wdata", 64'(wdata), 64'hFFFF_FF80);
        chk("t1_we", 64'(mwe), 64'd1);
        chk("t1_waddr", 64'(mwa), 64'd5);
        chk("t1_pc", 64'(mpc), 64'h100);
        tick();
        #1 chk("t1_gone", 64'(mvalid), 64'd0);

        // ld.hu at 0x2 held by WB back-pressure; a waiting ALU op enters when it leaves
        wsa = 1'b0;
        issue(32'h200, 1, 1, 1, 5'd7, 32'h2, LD_HU);
        tick(); idle();
        dok = 1'b1; rd = 32'hBEEF_1234;
        tick();
        dok = 1'b0; rd = 32'hDEAD_DEAD;
        issue(32'h210, 0, 0, 1, 5'd8, 32'h55, LD_W);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_wdata", 64'(wdata), 64'h0000_BEEF);
            chk("t2_valid", 64'(mvalid), 64'd1);
            chk("t2_allowin", 64'(allowin), 64'd0);
            chk("t2_pc", 64'(mpc), 64'h200);
            tick();
        end
        wsa = 1'b1;
        #1 chk("t2_allowin_go", 64'(allowin), 64'd1);
        tick(); idle();
        #1 chk("t2_next_pc", 64'(mpc), 64'h210);
        chk("t2_next_wdata", 64'(wdata), 64'h55);
        tick();
        #1 chk("t2_gone", 64'(mvalid), 64'd0);

        // back-to-back ALU results
        vals[0] = 32'h1111_1111; vals[1] = 32'h2222_0000; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            issue(32'h400 + 32'(i * 4), 0, 0, (i % 2 == 0), 5'(i + 1), vals[i], LD_B);
            #1 chk("t3_allowin", 64'(allowin), 64'd1);
            if (i > 0) begin
                chk("t3_valid", 64'(mvalid), 64'd1);
                chk("t3_wdata", 64'(wdata), 64'(vals[i-1]));
                chk("t3_we", 64'(mwe), 64'((i - 1) % 2 == 0));
            end
            tick();
        end
        idle();
        #1 chk("t3_last", 64'(wdata), 64'(vals[3]));
        chk("t3_last_we", 64'(mwe), 64'd0);
        tick();
        #1 chk("t3_gone", 64'(mvalid), 64'd0);

        // flush one cycle after a load, response two cycles later
        issue(32'h500, 1, 1, 1, 5'd9, 32'h0, LD_W);
        tick(); idle();
        fl = 1'b1;
        #1 chk("t4_allowin_f", 64'(allowin), 64'd0);
        tick(); fl = 1'b0;
        #1 chk("t4_state", 64'(u32.state_q), 64'(ST_DISCARD));
        chk("t4_valid", 64'(mvalid), 64'd0);
        chk("t4_allowin", 64'(allowin), 64'd0);
        chk("t4_fwd", 64'(fwd), 64'd0);
        tick();
        dok = 1'b1; rd = 32'h1234_5678;
        #1 chk("t4_allowin_d", 64'(allowin), 64'd0);
        chk("t4_valid_d", 64'(mvalid), 64'd0);
        tick(); dok = 1'b0;
        #1 chk("t4_empty", 64'(u32.state_q), 64'(ST_EMPTY));
        chk("t4_valid_e", 64'(mvalid), 64'd0);
        chk("t4_allowin_e", 64'(allowin), 64'd1);
        issue(32'h600, 0, 0, 1, 5'd2, 32'hABCD, LD_W);
        tick(); idle();
        #1 chk("t4_next", 64'(wdata), 64'hABCD);
        chk("t4_next_v", 64'(mvalid), 64'd1);
        tick();

        // flush together with the response drops it
        issue(32'h700, 1, 1, 1, 5'd4, 32'h0, LD_W);
        tick(); idle();
        fl = 1'b1; dok = 1'b1; rd = 32'hCAFE_F00D;
        tick(); fl = 1'b0; dok = 1'b0;
        #1 chk("t4b_state", 64'(u32.state_q), 64'(ST_EMPTY));
        chk("t4b_valid", 64'(mvalid), 64'd0);

        // flush in READY while WB stalls
        wsa = 1'b0;
        issue(32'h710, 0, 0, 1, 5'd4, 32'h77, LD_W);
        tick(); idle();
        #1 chk("t4c_ready", 64'(mvalid), 64'd1);
        fl = 1'b1;
        tick(); fl = 1'b0; wsa = 1'b1;
        #1 chk("t4c_valid", 64'(mvalid), 64'd0);

        // flush beats a simultaneous accept
        issue(32'h720, 0, 0, 1, 5'd4, 32'h88, LD_W);
        fl = 1'b1;
        tick(); fl = 1'b0; idle();
        #1 chk("t4d_valid", 64'(mvalid), 64'd0);

        // XLEN=64 word/doubleword loads
        ld64("t5_w",  LD_W,  64'h4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
        ld64("t5_wu", LD_WU, 64'h4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
        ld64("t5_d",  LD_D,  64'h4, 64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000);
        ld64("t5_b7", LD_B,  64'h7, 64'h8100_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF81);

        // asynchronous reset during WAIT, then a stray response
        issue(32'h300, 1, 1, 1, 5'd6, 32'h44, LD_W);
        tick(); idle();
        #1 chk("t6_fwd", 64'(fwd), 64'd1);
        #1 reset = 1'b1;
        #1 chk("t6_state", 64'(u32.state_q), 64'(ST_EMPTY));
        chk("t6_pc", 64'(mpc), 64'd0);
        chk("t6_valid", 64'(mvalid), 64'd0);
        chk("t6_we", 64'(mwe), 64'd0);
        chk("t6_wdata", 64'(wdata), 64'd0);
        chk("t6_fwd0", 64'(fwd), 64'd0);
        #1 reset = 1'b0;
        stray_ok = 1'b1; dok = 1'b1; rd = 32'hFFFF_FFFF;
        tick(); dok = 1'b0; stray_ok = 1'b0;
        #1 chk("t6_stray_state", 64'(u32.state_q), 64'(ST_EMPTY));
        chk("t6_stray_valid", 64'(mvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
Parametrised memory-access pipeline stage between EX and WB. Successor to the fixed 32-bit single-cycle MEM register.
- Supports a data SRAM with split request/response (data_ok may arrive N≥1 cycles after EX issued the request).
- Buffers returned data while WB back-pressures and discards responses of flushed loads.
- Performs lane select plus sign/zero extension for XLEN=32 or 64, and exposes forwarding/stall info to EX.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
PC_W, 32, PC width.
RA_W, 5, register-file address width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
es_to_ms_valid  in  1  EX holds a valid instruction
ms_allowin  out  1  MEM accepts from EX this cycle
es_pc  in  PC_W  instruction PC
es_res_from_mem  in  1  result comes from a load
es_mem_req  in  1  EX issued an accepted data-SRAM read request for this instruction
es_rf_we  in  1  writes register file
es_rf_waddr  in  RA_W  destination register
es_alu_result  in  XLEN  ALU result / effective address
es_ld_op  in  3  0 W, 1 H, 2 HU, 3 B, 4 BU, 5 D, 6 WU (5 and 6 only when XLEN=64)
data_sram_data_ok  in  1  read data valid this cycle
data_sram_rdata  in  XLEN  read data
ms_flush  in  1  kill the MEM instruction (exception/ertn)
ws_allowin  in  1  WB accepts
ms_to_ws_valid  out  1  MEM result valid to WB
ms_pc  out  PC_W  PC to WB
ms_rf_we  out  1  write enable, already gated by ms_valid
ms_rf_waddr  out  RA_W  destination
ms_rf_wdata  out  XLEN  final write data
ms_fwd_blocked  out  1  ms_valid & es_res_from_mem-latched & data not yet available; EX stalls dependents

Behaviour:
- States: EMPTY, WAIT (load outstanding), READY (result available), DISCARD (flushed load outstanding). Reset → EMPTY, asynchronously.
- On reset, all registered outputs are 0: ms_to_ws_valid=0, ms_pc=0, ms_rf_we=0, ms_rf_wdata=0.
- ms_allowin = (state==EMPTY) | (state==READY & ws_allowin). It is 0 in WAIT and DISCARD.
- Accept = es_to_ms_valid & ms_allowin & ~ms_flush. On accept, latch all es_* fields.
  - Next state is WAIT if es_mem_req, else READY.
  - Accept with no new instruction while READY & ws_allowin → EMPTY.
- WAIT: on data_sram_data_ok, capture rdata into rdata_buf and go to READY. Data is usable by WB in the following cycle; there is no same-cycle bypass of rdata.
- READY: ms_to_ws_valid=1. The instruction is held, with rdata_buf stable, until ws_allowin.
- Flush:
  - ms_flush in READY → EMPTY.
  - ms_flush in WAIT without data_ok → DISCARD.
  - ms_flush in WAIT with data_ok in the same cycle → EMPTY, data dropped.
  - In DISCARD, the next data_ok is dropped → EMPTY. Flush in EMPTY or DISCARD has no effect.
  - ms_flush has priority over accept.
- Responses: exactly one data_ok per es_mem_req. data_ok in EMPTY or READY is a protocol error; the design ignores it and the bench asserts it never occurs.
- Extension (load result computed from rdata_buf):
  - Byte lane = alu_result[log2(XLEN/8)-1:0]. Halves use the lane aligned down to 2 bytes, words to 4 bytes.
  - W/H/B sign-extend to XLEN. HU/BU/WU zero-extend. D passes through.
  - W at XLEN=32 passes through.
  - Misalignment is not checked here (EX raises ALE).
- ms_rf_wdata = res_from_mem ? extended : alu_result.
- ms_rf_we = latched_we & ms_to_ws_valid.
- ms_fwd_blocked = (state==WAIT).

Decomposition:
- Package mem_pkg holds:
  - the ld_op encodings (LD_W..LD_WU) and the state encoding;
  - the function lane_extend(rdata, addr_lo, ld_op).
- One sub-module, load_extend (purely combinational, parametrised by XLEN), implements lane select and extension. It is tested standalone.

Test Plan:
- ld.b at address 0x1003, XLEN=32, rdata 0x80FF_0000, data_ok 3 cycles after accept → ms_fwd_blocked high 3 cycles; then ms_rf_wdata 0xFFFF_FF80 with ms_to_ws_valid=1.
- ld.hu at address 0x2 with rdata 0xBEEF_1234, ws_allowin low for 4 cycles after data_ok → wdata holds 0x0000_BEEF, ms_allowin stays 0, the instruction leaves on the first ws_allowin.
- ALU instructions back-to-back with ws_allowin=1 → one result per cycle, ms_allowin stays 1, wdata equals alu_result.
- Load accepted, ms_flush 1 cycle later, data_ok 2 cycles after that with rdata 0x1234_5678 → state DISCARD, no ms_to_ws_valid, ms_allowin low until data_ok, then EMPTY and the next instruction accepted.
- XLEN=64 ld.w, address 0x4, rdata 0x8000_0001_0000_0000 → 0xFFFF_FFFF_8000_0001; same with ld.wu → 0x0000_0000_8000_0001; ld.d → raw data.
- Reset asserted during WAIT → outputs 0 immediately (asynchronously), state EMPTY, a later stray data_ok ignored.
